// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline control for the 5-stage RV32I core: carries ID control words through EX/MEM/WB,
// resolves RAW/load-use hazards, branch flushes and dmem freezes. Build option: PIPE_FWD_EN.
module rv32i_pipe_ctrl #(
  parameter int CTRL_W = 20,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_wr,
  input  logic              id_is_load,
  input  logic              ex_br_taken,
  input  logic              dmem_busy,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_wr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
    logic              is_load;
  } stage_t;

  stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_stage;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [REG_AW-1:0] id_src1, id_src2;
  logic              hit_ex, hit_mem, hazard, freeze, flush, stall;
  logic              unused_bits;

  // A stage "produces" r when it will write a non-zero register r.
  function automatic logic produces(input stage_t s, input logic [REG_AW-1:0] r);
    return s.valid & s.reg_wr & (s.rd == r) & (r != '0);
  endfunction

  // Unused source fields are carried as x0 so they can never match or forward.
  assign id_src1 = id_use_rs1 ? id_rs1 : '0;
  assign id_src2 = id_use_rs2 ? id_rs2 : '0;

  always_comb begin
    id_stage         = '0;
    id_stage.valid   = 1'b1;
    id_stage.ctrl    = id_ctrl;
    id_stage.rs1     = id_src1;
    id_stage.rs2     = id_src2;
    id_stage.rd      = id_rd;
    id_stage.reg_wr  = id_reg_wr;
    id_stage.is_load = id_is_load;
  end

  assign hit_ex  = id_valid & (produces(ex_q, id_src1) | produces(ex_q, id_src2));
  assign hit_mem = id_valid & (produces(mem_q, id_src1) | produces(mem_q, id_src2));

`ifdef PIPE_FWD_EN
  assign hazard = hit_ex & ex_q.is_load;
`else
  assign hazard = hit_ex | hit_mem;
`endif

  // Priority: freeze > flush > hazard stall > advance.
  assign freeze = dmem_busy;
  assign flush  = ex_q.valid & ex_br_taken & ~freeze;
  assign stall  = freeze | (hazard & ~flush);

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (id_valid & ~flush & ~hazard) ? id_stage : '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // MEM match wins over WB: it is the younger producer.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
`ifdef PIPE_FWD_EN
    if (produces(mem_q, ex_q.rs1))     fwd_a = 2'b01;
    else if (produces(wb_q, ex_q.rs1)) fwd_a = 2'b10;
    if (produces(mem_q, ex_q.rs2))     fwd_b = 2'b01;
    else if (produces(wb_q, ex_q.rs2)) fwd_b = 2'b10;
`endif
  end

  // Hazard outputs depend on live inputs, so gate them with reset as well.
  assign stall_if  = rst & stall;
  assign stall_id  = rst & stall;
  assign flush_id  = rst & flush;
  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;
  assign ex_ctrl   = ex_q.ctrl;
  assign mem_ctrl  = mem_q.ctrl;
  assign wb_ctrl   = wb_q.ctrl;
  assign wb_rd     = wb_q.rd;
  assign wb_reg_wr = wb_q.valid & wb_q.reg_wr & (wb_q.rd != '0);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign unused_bits = ^{ex_q.rs1, ex_q.rs2, mem_q.rs1, mem_q.rs2, mem_q.is_load,
                         wb_q.rs1, wb_q.rs2, wb_q.is_load, hit_mem};

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Bench for rv32i_pipe_ctrl: directed scenarios then random traffic, all checked each cycle
// against an in-flight instruction model; a second instance with CNT_W=2 checks saturation.
module tb_rv32i_pipe_ctrl;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_is_load, ex_br_taken, dmem_busy;
  logic [19:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall_if, stall_id, flush_id, ex_valid, mem_valid, wb_valid, wb_reg_wr;
  logic [19:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  wb_rd;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_stall_if, s_stall_id, s_flush_id, s_ex_valid, s_mem_valid, s_wb_valid, s_wb_reg_wr;
  logic [19:0] s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [4:0]  s_wb_rd;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  rv32i_pipe_ctrl #(.CTRL_W(20), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  rv32i_pipe_ctrl #(.CTRL_W(20), .REG_AW(5), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .flush_id(s_flush_id),
    .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
    .ex_valid(s_ex_valid), .mem_valid(s_mem_valid), .wb_valid(s_wb_valid),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .wb_rd(s_wb_rd), .wb_reg_wr(s_wb_reg_wr),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [19:0] ctrl;
    logic [4:0]  rs1, rs2, rd;
    bit          u1, u2, wr, ld;
  } ins_t;

  ins_t pipe [3];            // age 0 = in EX, 1 = in MEM, 2 = in WB
  int   exp_stall, exp_flush, exp_small_stall;
  bit   m_stall, m_flush;    // model verdict of the most recent cycle
  int   n_chk, n_pass;

  function automatic ins_t bubble();
    ins_t b;
    b = '{v: 1'b0, ctrl: '0, rs1: '0, rs2: '0, rd: '0, u1: 1'b0, u2: 1'b0, wr: 1'b0, ld: 1'b0};
    return b;
  endfunction

  function automatic bit produces(ins_t p, logic [4:0] r);
    return p.v && p.wr && (r != 0) && (p.rd == r);
  endfunction

  // Does the ID instruction have to wait on an older producer of register r?
  function automatic bit must_wait(logic [4:0] r, bit used);
    if (!id_valid || !used) return 1'b0;
    for (int age = 0; age < 2; age++)
      if (produces(pipe[age], r)) begin
        if (FWD) return (age == 0) && pipe[0].ld;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Operand source for the instruction in EX: nearest older producer wins.
  function automatic logic [1:0] exp_fwd(logic [4:0] r, bit used);
    if (!FWD || !pipe[0].v || !used) return 2'b00;
    for (int age = 1; age <= 2; age++)
      if (produces(pipe[age], r)) return (age == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = bubble();
    exp_stall = 0; exp_flush = 0; exp_small_stall = 0;
    m_stall = 1'b0; m_flush = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Inputs are already driven (just after a negedge); check, advance the model, go to next negedge.
  task automatic step();
    bit   frz, fl, haz, st;
    ins_t cur;
    #1;
    frz = dmem_busy;
    fl  = !frz && pipe[0].v && ex_br_taken;
    haz = must_wait(id_rs1, id_use_rs1) || must_wait(id_rs2, id_use_rs2);
    st  = frz || (haz && !fl);
    chk("stall_if", stall_if, st);
    chk("stall_id", stall_id, st);
    chk("flush_id", flush_id, fl);
    chk("fwd_a", fwd_a, exp_fwd(pipe[0].rs1, pipe[0].u1));
    chk("fwd_b", fwd_b, exp_fwd(pipe[0].rs2, pipe[0].u2));
    chk("ex_valid", ex_valid, pipe[0].v);
    chk("mem_valid", mem_valid, pipe[1].v);
    chk("wb_valid", wb_valid, pipe[2].v);
    chk("ex_ctrl", ex_ctrl, pipe[0].ctrl);
    chk("mem_ctrl", mem_ctrl, pipe[1].ctrl);
    chk("wb_ctrl", wb_ctrl, pipe[2].ctrl);
    chk("wb_rd", wb_rd, pipe[2].rd);
    chk("wb_reg_wr", wb_reg_wr, produces(pipe[2], pipe[2].rd));
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("flush_cnt", flush_cnt, exp_flush);
    chk("small_stall_cnt", s_stall_cnt, exp_small_stall);
    if (st) begin
      if (exp_stall < 65535) exp_stall++;
      if (exp_small_stall < 3) exp_small_stall++;
    end
    if (fl && exp_flush < 65535) exp_flush++;
    if (!frz) begin
      cur = '{v: 1'b1, ctrl: id_ctrl, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
              u1: id_use_rs1, u2: id_use_rs2, wr: id_reg_wr, ld: id_is_load};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id_valid && !fl && !haz) ? cur : bubble();
    end
    m_stall = st;
    m_flush = fl;
    @(negedge clk);
  endtask

  task automatic set_id(bit v, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                        logic [4:0] rd, bit wr, bit ld);
    id_valid = v; id_ctrl = 20'($urandom);
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_wr = wr; id_is_load = ld;
  endtask

  // Present one instruction in ID and hold it (as IF/ID would) until it is accepted.
  task automatic issue(bit v, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                       logic [4:0] rd, bit wr, bit ld, bit br);
    int n;
    set_id(v, rs1, u1, rs2, u2, rd, wr, ld);
    ex_br_taken = br; dmem_busy = 1'b0;
    step();
    n = 0;
    while (m_stall && n < 8) begin
      ex_br_taken = 1'b0;
      step();
      n++;
    end
    n_chk++;
    assert (n < 8) n_pass++;
    else $error("FAIL stall_bound observed=%0d expected=<8", n);
  endtask

  task automatic nops(int k);
    for (int i = 0; i < k; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int c0;
    n_chk = 0; n_pass = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_br_taken = 1'b0; dmem_busy = 1'b0;
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // add x5 ; add x6,x5 back-to-back, then with one-instruction gap
    issue(1, 1, 1, 2, 1, 5, 1, 0, 0);
    issue(1, 5, 1, 0, 0, 6, 1, 0, 0);
    nops(3);
    issue(1, 1, 1, 2, 1, 5, 1, 0, 0);
    issue(1, 3, 1, 4, 1, 7, 1, 0, 0);
    issue(1, 5, 1, 0, 0, 6, 1, 0, 0);
    nops(3);

    // lw x5 ; add x6,x5
    c0 = exp_stall;
    issue(1, 2, 1, 0, 0, 5, 1, 1, 0);
    issue(1, 5, 1, 1, 1, 6, 1, 0, 0);
    nops(3);
    chk("load_use_stalls", stall_cnt - c0, FWD ? 1 : 2);

    // taken branch in EX beats the load-use stall pending in ID
    c0 = exp_flush;
    issue(1, 2, 1, 0, 0, 5, 1, 1, 0);
    issue(1, 5, 1, 0, 0, 6, 1, 0, 1);
    chk("flush_count", flush_cnt - c0, 1);
    chk("flush_ex_bubble", ex_valid, 0);
    nops(3);

    // dmem busy for three cycles with a taken branch in EX
    c0 = exp_flush;
    issue(1, 1, 1, 2, 1, 0, 0, 0, 0);
    set_id(1, 3, 1, 0, 0, 8, 1, 0);
    ex_br_taken = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    dmem_busy = 1'b0;
    step();
    chk("freeze_then_flush", flush_cnt - c0, 1);
    nops(3);

    // writes to x0 then a reader of x0
    issue(1, 1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 0, 1, 0, 1, 9, 1, 0, 0);
    issue(1, 0, 1, 0, 0, 0, 1, 1, 0);
    issue(1, 0, 1, 0, 1, 4, 1, 0, 0);
    nops(3);

    // reset in the middle of a stall
    issue(1, 1, 1, 0, 0, 5, 1, 0, 0);
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    dmem_busy = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_stall_id", stall_id, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_flush_id", flush_id, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_stall_cnt_mid", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // five freeze cycles saturate the 2-bit counter at 3
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    dmem_busy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    dmem_busy = 1'b0;
    chk("sat_small", s_stall_cnt, 3);
    chk("sat_wide", stall_cnt, 5);

    // random traffic on a small register space to provoke hazards
    for (int i = 0; i < 500; i++) begin
      if (!m_stall) begin
        if (m_flush) set_id(0, 0, 0, 0, 0, 0, 0, 0);
        else set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                    5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                    1'($urandom), $urandom_range(0, 2) == 0);
      end
      ex_br_taken = ($urandom_range(0, 6) == 0);
      dmem_busy   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
